// File: rtl/axi4_lite_cmd_master.sv
// axi4_lite_cmd_master: single-outstanding command to AXI4-lite master bridge.
// Optional wr/rd/err counters are enabled with AXI4_LITE_CMD_MASTER_STATS_EN.
module axi4_lite_cmd_master #(
  parameter int A = 16,
  parameter int N = 4
) (
  input  logic           aclk,
  input  logic           areset,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic           cmd_write,
  input  logic [A-1:0]   cmd_addr,
  input  logic [N*8-1:0] cmd_wdata,
  input  logic [N-1:0]   cmd_wstrb,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [N*8-1:0] rsp_rdata,
  output logic [1:0]     rsp_resp,
  output logic [A-1:0]   awaddr,
  output logic [2:0]     awprot,
  output logic           awvalid,
  input  logic           awready,
  output logic [N*8-1:0] wdata,
  output logic [N-1:0]   wstrb,
  output logic           wvalid,
  input  logic           wready,
  input  logic [1:0]     bresp,
  input  logic           bvalid,
  output logic           bready,
  output logic [A-1:0]   araddr,
  output logic [2:0]     arprot,
  output logic           arvalid,
  input  logic           arready,
  input  logic [N*8-1:0] rdata,
  input  logic [1:0]     rresp,
  input  logic           rvalid,
  output logic           rready
`ifdef AXI4_LITE_CMD_MASTER_STATS_EN
  ,
  output logic [15:0]    wr_count,
  output logic [15:0]    rd_count,
  output logic [15:0]    err_count
`endif
);
  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE} state_t;
  state_t state_q, state_d;
  logic [A-1:0] addr_q, addr_d;
  logic [N*8-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [N-1:0] wstrb_q, wstrb_d;
  logic [1:0] resp_q, resp_d;
  logic aw_done_q, aw_done_d, w_done_q, w_done_d;
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
      resp_q    <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    rdata_d   = rdata_q;
    resp_d    = resp_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    case (state_q)
      IDLE: if (cmd_valid) begin
        addr_d    = cmd_addr;
        wdata_d   = cmd_wdata;
        wstrb_d   = cmd_wstrb;
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        state_d   = cmd_write ? WR_REQ : RD_REQ;
      end
      // AW and W complete independently; leave once both are done, even in the same cycle
      WR_REQ: begin
        aw_done_d = aw_done_q | awready;
        w_done_d  = w_done_q | wready;
        state_d   = (aw_done_d && w_done_d) ? WR_RESP : WR_REQ;
      end
      WR_RESP: if (bvalid) begin
        resp_d  = bresp;
        rdata_d = '0;
        state_d = DONE;
      end
      RD_REQ: state_d = arready ? RD_RESP : RD_REQ;
      RD_RESP: if (rvalid) begin
        resp_d  = rresp;
        rdata_d = rdata;
        state_d = DONE;
      end
      DONE: state_d = rsp_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  assign cmd_ready = state_q == IDLE && !areset;
  assign awvalid   = state_q == WR_REQ && !aw_done_q;
  assign wvalid    = state_q == WR_REQ && !w_done_q;
  assign bready    = state_q == WR_RESP;
  assign arvalid   = state_q == RD_REQ;
  assign rready    = state_q == RD_RESP;
  assign rsp_valid = state_q == DONE;
  assign awaddr    = addr_q;
  assign araddr    = addr_q;
  assign wdata     = wdata_q;
  assign wstrb     = wstrb_q;
  assign awprot    = 3'b000;
  assign arprot    = 3'b000;
  assign rsp_rdata = rdata_q;
  assign rsp_resp  = resp_q;
`ifdef AXI4_LITE_CMD_MASTER_STATS_EN
  logic [15:0] wr_q, rd_q, err_q;
  logic done_e;
  assign done_e = state_q != DONE && state_d == DONE;
  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      err_q <= '0;
    end else if (done_e) begin
      if (state_q == WR_RESP && wr_q != 16'hFFFF) wr_q <= wr_q + 16'd1;
      if (state_q == RD_RESP && rd_q != 16'hFFFF) rd_q <= rd_q + 16'd1;
      if (resp_d != 2'b00 && err_q != 16'hFFFF) err_q <= err_q + 16'd1;
    end
  end
  assign wr_count  = wr_q;
  assign rd_count  = rd_q;
  assign err_count = err_q;
`endif
endmodule
